// File: rtl/even_clk_div6.sv
// even_clk_div6: even-ratio clock divider, out_clk = clk/DIV at 50% duty, driven straight from a flop.
module even_clk_div6 #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic rst_n,
  output logic out_clk
);
  localparam int HALF = DIV / 2;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  if ((DIV < 2) || (DIV % 2 != 0)) begin : g_bad_div
    $fatal(1, "even_clk_div6: DIV must be an even integer >= 2");
  end
  logic [CW-1:0] cnt;
  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
      out_clk <= 1'b0;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt <= '0;
      out_clk <= ~out_clk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_even_clk_div6.sv
// tb_even_clk_div6: table-driven check of the divider at DIV = 6, 2, 4, 10 plus async-reset corner sequences.
module tb_even_clk_div6;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic o6, o2, o4, o10;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic rst;
    logic e6;
    logic e2;
    logic e4;
    logic e10;
  } vec_t;
  vec_t vec[64];
  logic [0:59] p6, p2, p4, p10;

  even_clk_div6 #(.DIV(6))  dut   (.clk(clk), .rst_n(rst_n), .out_clk(o6));
  even_clk_div6 #(.DIV(2))  dut2  (.clk(clk), .rst_n(rst_n), .out_clk(o2));
  even_clk_div6 #(.DIV(4))  dut4  (.clk(clk), .rst_n(rst_n), .out_clk(o4));
  even_clk_div6 #(.DIV(10)) dut10 (.clk(clk), .rst_n(rst_n), .out_clk(o10));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  initial begin
    // Expected out_clk after rising edges 1..60 following reset release
    p6  = {10{6'b001110}};
    p2  = {30{2'b10}};
    p4  = {15{4'b0110}};
    p10 = {6{10'b0000111110}};
    for (int i = 0; i < 4; i++) vec[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 60; i++) vec[i+4] = '{1'b0, p6[i], p2[i], p4[i], p10[i]};
    #1;
    chk("reset_out6", o6, 1'b0);
    chk("reset_cnt6", dut.cnt == 0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rst_n = vec[i].rst;
      @(posedge clk);
      #1;
      chk("div6", o6, vec[i].e6);
      chk("div2", o2, vec[i].e2);
      chk("div4", o4, vec[i].e4);
      chk("div10", o10, vec[i].e10);
      if (vec[i].rst) chk("reset_cnt", dut.cnt == 0, 1'b1);
      #3;
      chk("div6_stable", o6, vec[i].e6);
      chk("div2_stable", o2, vec[i].e2);
    end
    // Restart cleanly, then hit reset in the middle of the first high phase
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("pre_mid_rst", o6, p6[k]);
    end
    #3;
    rst_n = 1'b1;
    #1;
    chk("async_rst_out6", o6, 1'b0);
    chk("async_rst_out10", o10, 1'b0);
    chk("async_rst_cnt", dut.cnt == 0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("held_rst_out", o6 | o2 | o4 | o10, 1'b0);
      chk("held_rst_cnt", dut.cnt == 0, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_div6", o6, p6[k]);
      chk("post_rst_div10", o10, p10[k]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
